// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// The request struct is sized to the default RAM geometry.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_IF,
      RESP_D
   } resp_owner_t;

   localparam int unsigned DEF_STARVE_MAX = 4;
   localparam int unsigned MEM_ADDR_W     = 14;
   localparam int unsigned MEM_DATA_W     = 32;
   localparam int unsigned MEM_BE_W       = MEM_DATA_W / 8;

   typedef struct packed {
      logic                  we;
      logic [MEM_BE_W-1:0]   be;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles.
// force_if tells the arbiter that fetch must win this cycle.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic CLK,
   input  logic RST,
   input  logic starving,
   input  logic granted,
   output logic force_if
);

   localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

   logic [3:0] cnt;

   // A cycle without a fetch request leaves the count untouched.
   always_ff @(posedge CLK) begin
      if (RST || granted) begin
         cnt <= '0;
      end else if (starving && cnt != MAX_C) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign force_if = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported synchronous RAM (fetch vs data).
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_if_stall,
   output logic [31:0]         perf_d_acc
`endif
);

   localparam int unsigned BE_W = DATA_W / 8;

   logic        force_if;
   resp_owner_t state, state_nxt;
   mem_req_t    if_side, d_side, sel;

   arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .CLK      (CLK),
      .RST      (RST),
      .starving (stall_if),
      .granted  (if_gnt),
      .force_if (force_if)
   );

   // Grants are masked during reset so nothing reaches the RAM.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!RST) begin
         if (if_req && (!d_req || force_if)) begin
            if_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end
      end
   end

   assign stall_if = ~RST & if_req & ~if_gnt;

   always_comb begin
      if_side       = '0;
      if_side.be    = '1;
      if_side.addr  = MEM_ADDR_W'(if_addr);
      d_side.we     = d_we;
      d_side.be     = MEM_BE_W'(d_be);
      d_side.addr   = MEM_ADDR_W'(d_addr);
      d_side.wdata  = MEM_DATA_W'(d_wdata);
      sel           = '0;
      if (if_gnt) begin
         sel = if_side;
      end else if (d_gnt) begin
         sel = d_side;
      end
   end

   assign mem_en    = if_gnt | d_gnt;
   assign mem_we    = sel.we;
   assign mem_be    = BE_W'(sel.be);
   assign mem_addr  = ADDR_W'(sel.addr);
   assign mem_wdata = DATA_W'(sel.wdata);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= RESP_NONE;
      end else begin
         state <= state_nxt;
      end
   end

   // rvalid is also masked by RST so an in-flight read is dropped at once.
   always_comb begin
      state_nxt = RESP_NONE;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if (if_gnt) begin
         state_nxt = RESP_IF;
      end else if (d_gnt && !d_we) begin
         state_nxt = RESP_D;
      end
      if (!RST) begin
         if_rvalid = (state == RESP_IF);
         d_rvalid  = (state == RESP_D);
      end
   end

   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_if_stall <= '0;
         perf_d_acc    <= '0;
      end else begin
         if (stall_if) perf_if_stall <= perf_if_stall + 32'd1;
         if (d_gnt)    perf_d_acc    <= perf_d_acc + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model
// and a small RAM attached to the memory port.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 14;
   localparam int unsigned DW   = 32;
   localparam int unsigned SMAX = 4;
   localparam int unsigned WORDS = 1 << AW;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [3:0]    d_be = '0;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_en, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          stall_if;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]   perf_if_stall, perf_d_acc;
`endif

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .STARVE_MAX(SMAX)
   ) dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_if(stall_if)
`ifdef MEM_ARB_PERF_EN
      , .perf_if_stall(perf_if_stall), .perf_d_acc(perf_d_acc)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM environment: answers the DUT's memory port one cycle later
   logic [DW-1:0] ram [0:WORDS-1];
   always @(posedge CLK) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end else begin
         mem_rdata <= 32'h0BAD_F00D;
      end
   end

   // Reference model: evaluated at negedge, inputs are stable until the next posedge
   logic [DW-1:0] ref_mem [0:WORDS-1];
   int            starve = 0;
   bit            pend_if = 0, pend_d = 0;
   logic [DW-1:0] pend_data = '0;

   always @(negedge CLK) begin : model
      bit e_if, e_d;
      if (RST) begin
         chk("rst_if_gnt", {63'd0, if_gnt}, 64'd0);
         chk("rst_d_gnt", {63'd0, d_gnt}, 64'd0);
         chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
         chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
         chk("rst_if_rvalid", {63'd0, if_rvalid}, 64'd0);
         chk("rst_d_rvalid", {63'd0, d_rvalid}, 64'd0);
         chk("rst_stall_if", {63'd0, stall_if}, 64'd0);
         starve  = 0;
         pend_if = 0;
         pend_d  = 0;
      end else begin
         e_if = if_req && (!d_req || starve == SMAX);
         e_d  = d_req && !e_if;
         chk("if_gnt", {63'd0, if_gnt}, {63'd0, e_if});
         chk("d_gnt", {63'd0, d_gnt}, {63'd0, e_d});
         chk("mem_en", {63'd0, mem_en}, {63'd0, e_if | e_d});
         chk("mem_we", {63'd0, mem_we}, {63'd0, e_d & d_we});
         chk("stall_if", {63'd0, stall_if}, {63'd0, if_req & !e_if});
         chk("if_rvalid", {63'd0, if_rvalid}, {63'd0, pend_if});
         chk("d_rvalid", {63'd0, d_rvalid}, {63'd0, pend_d});
         if (pend_if) chk("if_rdata", {32'd0, if_rdata}, {32'd0, pend_data});
         if (pend_d)  chk("d_rdata", {32'd0, d_rdata}, {32'd0, pend_data});
         if (e_if) begin
            chk("if_mem_addr", {50'd0, mem_addr}, {50'd0, if_addr});
            chk("if_mem_be", {60'd0, mem_be}, 64'hF);
         end
         if (e_d) begin
            chk("d_mem_addr", {50'd0, mem_addr}, {50'd0, d_addr});
            chk("d_mem_be", {60'd0, mem_be}, {60'd0, d_be});
            if (d_we) chk("d_mem_wdata", {32'd0, mem_wdata}, {32'd0, d_wdata});
         end
         pend_if = e_if;
         pend_d  = e_d && !d_we;
         if (e_if) pend_data = ref_mem[if_addr];
         else if (pend_d) pend_data = ref_mem[d_addr];
         if (e_d && d_we)
            for (int b = 0; b < 4; b++)
               if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
         if (e_if) starve = 0;
         else if (if_req && starve < SMAX) starve++;
      end
   end

   // Drive one cycle of inputs after the posedge, return just after the negedge
   task automatic cyc(input logic rst, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic we, input logic [AW-1:0] da,
                      input logic [DW-1:0] wd, input logic [3:0] be);
      @(posedge CLK);
      #1;
      RST = rst; if_req = ir; if_addr = ia;
      d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
      @(negedge CLK);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [5:0] ig, dg, st;
      logic [4:0] ig5;
      for (int unsigned i = 0; i < WORDS; i++) begin
         ram[i]     = {16'hC0DE, 2'b00, i[13:0]};
         ref_mem[i] = {16'hC0DE, 2'b00, i[13:0]};
      end
      ram[14'h010]     = 32'h0050_0093;
      ref_mem[14'h010] = 32'h0050_0093;

      // Reset held two cycles with both requesters active
      RST = 1'b1; if_req = 1'b1; d_req = 1'b1; d_addr = 14'h200;
      cyc(1'b1, 1'b1, 14'h020, 1'b1, 1'b0, 14'h200, '0, 4'hF);
      cyc(1'b1, 1'b1, 14'h020, 1'b1, 1'b0, 14'h200, '0, 4'hF);
      chk("lit_rst_gnts", {62'd0, if_gnt, d_gnt}, 64'd0);
      cyc(1'b0, 1'b1, 14'h020, 1'b1, 1'b0, 14'h200, '0, 4'hF);
      chk("lit_first_d_gnt", {62'd0, if_gnt, d_gnt}, 64'd1);

      // Fetch only
      cyc(1'b0, 1'b1, 14'h010, 1'b0, 1'b0, '0, '0, 4'h0);
      chk("lit_fetch_gnt", {62'd0, if_gnt, stall_if}, 64'd2);
      chk("lit_load_rdata", {32'd0, d_rdata}, 64'hC0DE0200);
      idle();
      chk("lit_fetch_rvalid", {63'd0, if_rvalid}, 64'd1);
      chk("lit_fetch_rdata", {32'd0, if_rdata}, 64'h00500093);

      // Contention: data wins four times, then fetch is forced through
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 1'b1, 14'h020, 1'b1, 1'b0, AW'(14'h300 + k), '0, 4'hF);
         ig[k] = if_gnt; dg[k] = d_gnt; st[k] = stall_if;
      end
      chk("lit_cont_if_gnt", {58'd0, ig}, 64'b010000);
      chk("lit_cont_d_gnt", {58'd0, dg}, 64'b101111);
      chk("lit_cont_stall", {58'd0, st}, 64'b101111);
      idle();

      // Store: half-word write, no response
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 14'h100, 32'hDEADBEEF, 4'b0011);
      chk("lit_store_we_be", {59'd0, mem_we, mem_be}, 64'h13);
      chk("lit_store_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
      chk("lit_store_addr", {50'd0, mem_addr}, 64'h100);
      idle();
      chk("lit_store_no_rvalid", {63'd0, d_rvalid}, 64'd0);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h100, '0, 4'hF);
      idle();
      chk("lit_store_readback", {32'd0, d_rdata}, 64'hC0DEBEEF);

      // Interleave: fetch in N, load in N+1
      cyc(1'b0, 1'b1, 14'h020, 1'b0, 1'b0, '0, '0, 4'h0);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h030, '0, 4'hF);
      chk("lit_il_n1_valids", {62'd0, if_rvalid, d_rvalid}, 64'd2);
      chk("lit_il_if_rdata", {32'd0, if_rdata}, 64'hC0DE0020);
      idle();
      chk("lit_il_n2_valids", {62'd0, if_rvalid, d_rvalid}, 64'd1);
      chk("lit_il_d_rdata", {32'd0, d_rdata}, 64'hC0DE0030);

      // Build up some starvation, then reset in the middle of a read
      cyc(1'b0, 1'b1, 14'h020, 1'b1, 1'b0, 14'h041, '0, 4'hF);
      cyc(1'b0, 1'b1, 14'h020, 1'b1, 1'b0, 14'h042, '0, 4'hF);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h040, '0, 4'hF);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
      chk("lit_rst_drop_n1", {63'd0, d_rvalid}, 64'd0);
      idle();
      chk("lit_rst_drop_n2", {63'd0, d_rvalid}, 64'd0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1, 14'h021, 1'b1, 1'b0, AW'(14'h050 + k), '0, 4'hF);
         ig5[k] = if_gnt;
      end
      chk("lit_starve_cleared", {59'd0, ig5}, 64'b10000);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous RAM between two requesters.
- Requester 1 is the instruction-fetch stage; requester 2 is the data-memory stage (loads/stores).
- Decides which requester is granted each cycle, drives the RAM port, and routes read data back to the owning requester one cycle later.
- Produces a fetch-stall indication that the hazard logic uses to freeze PC and IF/ID.

Parameters:
- ADDR_W, 14, word-address width of the RAM.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive denied fetch cycles before fetch is forced to win (range 1..15).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_be  out  DATA_W/8  RAM byte enables
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read
- stall_if  out  1  equals if_req & ~if_gnt

Behaviour:
- Reset: all outputs except the data buses are 0. Starvation counter is 0 and the response FSM is RESP_NONE. if_rdata and d_rdata are don't-care while their rvalid is 0.
- Handshake:
  - A requester holds req and its payload stable until gnt.
  - gnt is combinational in the cycle of acceptance.
  - At most one grant per cycle.
  - A new grant is allowed every cycle; the RAM is fully pipelined.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on any cycle with if_req & ~if_gnt.
  - Clears on if_gnt.
  - Holds when if_req = 0.
- RAM drive:
  - mem_en = if_gnt | d_gnt.
  - mem_addr, mem_we, mem_be and mem_wdata come from the granted requester.
  - A fetch grant forces mem_we = 0 and mem_be = all ones.
  - With no grant, mem_we = 0.
- Response FSM, registered each cycle:
  - RESP_NONE: no read was granted last cycle.
  - RESP_IF: fetch read granted last cycle. Assert if_rvalid; if_rdata = mem_rdata.
  - RESP_D: data load granted last cycle. Assert d_rvalid; d_rdata = mem_rdata.
  - Next state depends only on this cycle's grant; a store grant leads to RESP_NONE.
  - Read latency is exactly 1 cycle from gnt to rvalid. Stores produce no rvalid.
- Back-to-back requests: fetch grant in cycle N and data grant in cycle N+1 give if_rvalid in N+1 and d_rvalid in N+2. No bubble.
- Reset mid-operation: when RST is asserted, a pending response is dropped, so no rvalid appears in the cycle after RST. The counter is cleared.
- No address range checks; address decode belongs upstream.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_if_stall[31:0], counting cycles with stall_if = 1.
  - Adds output perf_d_acc[31:0], counting d_gnt cycles.
  - Both wrap modulo 2^32 and are cleared by RST.
- Undefined: neither port nor its counter exists. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared package mem_arb_pkg:
  - enum resp_owner_t {RESP_NONE, RESP_IF, RESP_D}.
  - Constant DEF_STARVE_MAX = 4.
  - Struct mem_req_t {we, be, addr, wdata}.
- One sub-module, arb_starve_ctr: the saturating counter with a "force" output equal to (cnt == STARVE_MAX).
- Everything else stays in one module.

Test Plan:
- Reset: hold RST 2 cycles with both reqs high → all gnt/rvalid/mem_en = 0. Release → d_gnt = 1 in the first cycle.
- Fetch only: if_req = 1, if_addr = 0x0010, mem_rdata = 0x00500093 next cycle → if_gnt in the same cycle, if_rvalid = 1 with if_rdata = 0x00500093 one cycle later, stall_if = 0.
- Contention and starvation: both reqs held continuously with d_we = 0, STARVE_MAX = 4 → d_gnt for 4 cycles, if_gnt on the 5th, counter cleared, then d_gnt again. stall_if = 1 exactly in the 4 denied cycles.
- Store: d_req = 1, d_we = 1, d_addr = 0x0100, d_be = 4'b0011, d_wdata = 0xDEADBEEF → mem_we = 1, mem_be = 0011, mem_wdata = 0xDEADBEEF; no d_rvalid next cycle.
- Interleave: fetch granted in cycle N, load granted in N+1 → if_rvalid in N+1 only, d_rvalid in N+2 only, with data routed correctly.
- Reset mid-read: load granted in cycle N, RST = 1 in N+1 → d_rvalid = 0 in N+1 and N+2. Starve count is 0 after release.
